writeback_cycle: RTL
====================

Name: writeback_cycle

Overview:
Writeback stage of the 5-stage vector pipeline, and the producer side of the register-file write port (RegWriteW / RDW / ResultW) that decode consumes.
- Takes memory-stage results and selects ALU result or load data.
- For vector loads, gathers LANES 32-bit memory beats into one 128-bit result before committing.
- Stalls the memory stage while a gather is in progress.

Parameters:
LANES, 4, number of 32-bit beats per vector load (LANES*DATA_W = 128)
DATA_W, 32, memory read beat width
REG_AW, 6, register address width
TIMEOUT, 16, max idle cycles between beats (used only with WB_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
ValidM  input  1  memory-stage instruction valid
RegWriteM  input  1  instruction writes the register file
ResultSrcM  input  1  0 = ALU result, 1 = load data
vectorialM  input  1  instruction is vectorial
RD_M  input  REG_AW  destination register
ALUResultM  input  128  ALU result
ReadDataM  input  DATA_W  memory read beat
RdValidM  input  1  ReadDataM valid this cycle
StallW  output  1  memory stage must hold its outputs
RegWriteW  output  1  register-file write enable (1-cycle pulse)
RDW  output  REG_AW  write address
ResultW  output  128  write data
ErrW  output  1  gather timeout (WB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, lane index=0.
  - RegWriteW=0, RDW=0, ResultW=0, StallW=0, ErrW=0.
- States: IDLE, GATHER, COMMIT.
- StallW = (state != IDLE). It is decoded from registered state only, with no combinational path from inputs.
- Accept: ValidM=1 while state=IDLE.
  - ValidM during GATHER or COMMIT is ignored; upstream holds its outputs.
- IDLE, accepted, not (ResultSrcM & vectorialM):
  - Next cycle: RegWriteW=RegWriteM, RDW=RD_M.
  - ResultW = ResultSrcM ? {96'b0, ReadDataM} : ALUResultM.
  - Latency 1, state stays IDLE, back-to-back acceptance each cycle allowed.
  - Scalar load data must arrive with ValidM.
- IDLE, accepted, ResultSrcM=1 & vectorialM=1:
  - Latch RegWriteM and RD_M, clear the gather buffer, lane=0, go to GATHER.
  - RdValidM in the acceptance cycle is ignored.
- GATHER:
  - Each cycle with RdValidM=1: buffer[lane*32 +: 32] <= ReadDataM, lane++. Lane 0 is the LS word.
  - Cycles with RdValidM=0 insert gaps with no state change.
  - On the LANES-th beat: go to COMMIT.
- COMMIT (exactly 1 cycle):
  - RegWriteW = latched RegWriteM, RDW = latched RD, ResultW = buffer.
  - Next state IDLE; lane=0.
- Vector load total occupancy = 1 + LANES (gapless) + 1 cycles.
- Outside a commit cycle: RegWriteW=0, and RDW/ResultW hold their last committed values.
- RD=0 is passed through unchanged; the register file handles it.
- RdValidM in IDLE without a vector accept is ignored (except scalar-load data with ValidM).
- Reset mid-GATHER: partial data is discarded, no write is issued, IDLE on release.

Optional Feature:
WB_TIMEOUT_EN
- Defined:
  - Idle counter runs in GATHER and clears on each beat.
  - If it reaches TIMEOUT, abort: ErrW=1 for one cycle, no register write, state=IDLE, lane=0.
- Undefined:
  - No counter; GATHER waits indefinitely.
  - ErrW is constant 0.

Test Plan:
1. Reset release then ALU op: ValidM=1, ResultSrcM=0, RegWriteM=1, RD_M=5, ALUResultM=128'h0123..CDEF -> next cycle RegWriteW=1, RDW=5, ResultW=that value; StallW never 1.
2. Scalar load: ResultSrcM=1, vectorialM=0, RD_M=7, ReadDataM=32'hDEADBEEF -> next cycle RegWriteW=1, RDW=7, ResultW=128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF.
3. Vector load, gapless beats 11111111, 22222222, 33333333, 44444444:
   - StallW=1 for 5 cycles.
   - Then RegWriteW=1, RDW=RD_M, ResultW=128'h44444444_33333333_22222222_11111111.
4. Vector load with 2-cycle gaps between beats plus ValidM toggled during GATHER -> same result; no extra acceptance; commit 1 cycle after the 4th beat.
5. Assert rst after 2 beats -> immediate RegWriteW=0, StallW=0, ResultW=0; no write after release; the next ALU op completes normally.
6. WB_TIMEOUT_EN, TIMEOUT=16, vector load with only 1 beat -> ErrW=1 pulse after 16 idle cycles, RegWriteW stays 0, state returns to IDLE.

Source files
------------

// File: rtl/writeback_cycle.sv
// writeback_cycle -- writeback stage of the 5-stage vector pipeline.
//
// Drives the register-file write port (RegWriteW / RDW / ResultW) that decode
// consumes. Scalar results (ALU or single-beat load) commit one cycle after
// acceptance. A vector load gathers LANES memory beats into one wide result and
// commits it in a dedicated COMMIT cycle. The memory stage is stalled while
// this happens.
//
// Optional feature macro: WB_TIMEOUT_EN
//   defined   : a gather that sees TIMEOUT consecutive beat-less cycles is
//               aborted with a one-cycle ErrW pulse and no register write.
//   undefined : a gather waits indefinitely and ErrW is tied to 0.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   ValidM       memory-stage instruction valid
//   RegWriteM    instruction writes the register file
//   ResultSrcM   0 = ALU result, 1 = load data
//   vectorialM   instruction is vectorial
//   RD_M         destination register
//   ALUResultM   ALU result (LANES*DATA_W bits)
//   ReadDataM    memory read beat
//   RdValidM     ReadDataM valid this cycle
//   StallW       memory stage must hold its outputs
//   RegWriteW    register-file write enable (one-cycle pulse)
//   RDW          write address
//   ResultW      write data
//   ErrW         gather timeout pulse
module writeback_cycle #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ValidM,
  input  logic                      RegWriteM,
  input  logic                      ResultSrcM,
  input  logic                      vectorialM,
  input  logic [REG_AW-1:0]         RD_M,
  input  logic [LANES*DATA_W-1:0]   ALUResultM,
  input  logic [DATA_W-1:0]         ReadDataM,
  input  logic                      RdValidM,
  output logic                      StallW,
  output logic                      RegWriteW,
  output logic [REG_AW-1:0]         RDW,
  output logic [LANES*DATA_W-1:0]   ResultW,
  output logic                      ErrW
);

  localparam int RES_W  = LANES * DATA_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [RES_W-1:0]    gbuf_q, gbuf_d;
  logic                wen_lat_q, wen_lat_d;
  logic [REG_AW-1:0]   rd_lat_q, rd_lat_d;
  logic                regwrite_q, regwrite_d;
  logic [REG_AW-1:0]   rdw_q, rdw_d;
  logic [RES_W-1:0]    result_q, result_d;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    gbuf_d     = gbuf_q;
    wen_lat_d  = wen_lat_q;
    rd_lat_d   = rd_lat_q;
    regwrite_d = 1'b0;          // write enable is a pulse; only set on a commit
    rdw_d      = rdw_q;         // address/data hold their last committed value
    result_d   = result_q;
`ifdef WB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        lane_d = '0;
        if (ValidM) begin
          if (ResultSrcM && vectorialM) begin
            // Vector load: remember the destination, beats follow later.
            // A beat presented in this acceptance cycle is deliberately dropped.
            wen_lat_d = RegWriteM;
            rd_lat_d  = RD_M;
            gbuf_d    = '0;
            state_d   = S_GATHER;
`ifdef WB_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            regwrite_d = RegWriteM;
            rdw_d      = RD_M;
            result_d   = ResultSrcM ? {{(RES_W-DATA_W){1'b0}}, ReadDataM} : ALUResultM;
          end
        end
      end

      S_GATHER: begin
        if (RdValidM) begin
          gbuf_d[lane_q*DATA_W +: DATA_W] = ReadDataM;
`ifdef WB_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (lane_q == LAST_LANE) begin
            // Load the write port now so the write is visible during COMMIT.
            state_d    = S_COMMIT;
            lane_d     = '0;
            regwrite_d = wen_lat_q;
            rdw_d      = rd_lat_q;
            result_d   = gbuf_d;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          lane_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_COMMIT: begin
        state_d = S_IDLE;
        lane_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
        lane_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      gbuf_q     <= '0;
      wen_lat_q  <= 1'b0;
      rd_lat_q   <= '0;
      regwrite_q <= 1'b0;
      rdw_q      <= '0;
      result_q   <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      gbuf_q     <= gbuf_d;
      wen_lat_q  <= wen_lat_d;
      rd_lat_q   <= rd_lat_d;
      regwrite_q <= regwrite_d;
      rdw_q      <= rdw_d;
      result_q   <= result_d;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Stall comes from registered state only, never from the inputs.
  assign StallW    = (state_q != S_IDLE);
  assign RegWriteW = regwrite_q;
  assign RDW       = rdw_q;
  assign ResultW   = result_q;

`ifdef WB_TIMEOUT_EN
  assign ErrW = err_q;
`else
  assign ErrW = 1'b0;
`endif

endmodule
